// File: rtl/serial_adder.sv
// Bit-serial adder sequencer: one full-adder bit per clock, LSB first; SERIAL_ADDER_SUB_EN adds A-B mode.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH; WIDTH+2 cycles start to IDLE.
// Backpressure: none; start is sampled only in IDLE and ignored (not queued) while busy or done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             bit_s;
    logic             bit_c;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1, so Cout=1 means no borrow.
    assign b_load = sub ? ~B : B;
    assign c_load = sub ? 1'b1 : Cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = B;
    assign c_load     = Cin;
`endif

    assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign bit_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = b_load;
                    c_d     = c_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d    = bit_c;
                s_d    = {bit_s, s_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // c_q is the carry into the MSB, bit_c the carry out of it.
                    ovf_d   = c_q ^ bit_c;
                    cout_d  = bit_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign Cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed check of serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         ovf;

    int total;
    int bad;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, s} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
        logic [W-1:0] bv;
        logic         cv;
        logic [W:0]   sum;
        logic         ov;
        bv = b;
        cv = ci;
`ifdef SERIAL_ADDER_SUB_EN
        if (sb) begin
            bv = ~b;
            cv = 1'b1;
        end
`else
        if (sb) cv = ci;
`endif
        sum = {1'b0, a} + {1'b0, bv} + {{W{1'b0}}, cv};
        ov  = (a[W-1] == bv[W-1]) && (sum[W-1] != a[W-1]);
        return {ov, sum[W], sum[W-1:0]};
    endfunction

    // Runs one operation; poke_at>0 pulses a stray start with new operands during RUN.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb, input int poke_at, input int hold_n);
        logic [W+1:0] exp;
        int           busy_cnt;
        int           done_cnt;
        int           done_at;
        exp = model(a, b, ci, sb);
        @(negedge clk);
        A = a; B = b; Cin = ci; sub = sb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
                chk({tag, ".S"}, 32'(S), 32'(exp[W-1:0]));
                chk({tag, ".Cout"}, 32'(Cout), 32'(exp[W]));
                chk({tag, ".ovf"}, 32'(ovf), 32'(exp[W+1]));
            end
            start = (poke_at > 0 && k == poke_at);
            if (k <= W) begin
                A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
            end
        end
        start = 1'b0;
        chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(W));
        chk({tag, ".done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, ".done_at"}, 32'(done_at), 32'(W + 1));
        for (int h = 0; h < hold_n; h++) begin
            @(negedge clk);
            chk({tag, ".hold_S"}, 32'(S), 32'(exp[W-1:0]));
            chk({tag, ".hold_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int done_seen;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.S", 32'(S), 32'd0);
        chk("rst.Cout", 32'(Cout), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 0, 0);
        run_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
        run_op("cin", 8'h12, 8'h34, 1'b1, 1'b0, 0, 0);
        run_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 1'b0, 0, 0);
        run_op("ovf_neg", 8'h80, 8'h80, 1'b0, 1'b0, 0, 0);
        run_op("busy_ign", 8'h0F, 8'h01, 1'b0, 1'b0, 3, 5);

        // Abort an operation after its fourth RUN edge.
        @(negedge clk);
        A = 8'hF0; B = 8'h0F; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.S", 32'(S), 32'd0);
        chk("abort.Cout", 32'(Cout), 32'd0);
        chk("abort.ovf", 32'(ovf), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort.no_done", 32'(done_seen), 32'd0);
        run_op("after_rst", 8'h03, 8'h04, 1'b0, 1'b0, 0, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_neg", 8'h05, 8'h07, 1'b0, 1'b1, 0, 0);
        run_op("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 0, 0);
`else
        run_op("sub_ignored", 8'h05, 8'h07, 1'b1, 1'b1, 0, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   (n % 4 == 0) ? int'($urandom_range(1, W)) : 0, (n % 8 == 0) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder sequencer that drives one full-adder bit cell per clock, LSB first.
- Sits directly upstream of the single-bit full adder in the arithmetic unit. It loads WIDTH-bit operands, feeds one bit pair plus a registered carry to the cell each cycle, and collects the sum bits.
- Trades WIDTH cycles of latency for one full-adder cell.
- Reports the sum, carry-out and signed overflow with a start/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2 to 32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- A  in  WIDTH  operand A; captured on the accepting edge
- B  in  WIDTH  operand B; captured on the accepting edge
- Cin  in  1  carry-in; captured on the accepting edge
- sub  in  1  subtract request; captured on the accepting edge, ignored unless SERIAL_ADDER_SUB_EN
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when the result is complete
- S  out  WIDTH  sum result
- Cout  out  1  carry out of MSB
- ovf  out  1  signed (two's complement) overflow

Behaviour:
- Reset: asynchronous on rst_n low; all state cleared, state=IDLE, S=0, Cout=0, ovf=0, done=0, busy=0. The result registers are cleared too.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge: latch A and B into shift registers a_sh and b_sh, carry register c<=Cin, bit counter cnt<=0, go to RUN.
  - S, Cout and ovf keep their previous values until the first RUN edge.
- RUN: each edge does the following.
  - Compute bit s = a_sh[0]^b_sh[0]^c.
  - Update c <= majority(a_sh[0], b_sh[0], c).
  - Shift the sum register right, inserting s at bit WIDTH-1.
  - Shift a_sh and b_sh right by one.
  - Increment cnt.
- Last RUN edge (cnt==WIDTH-1):
  - Register ovf <= c_in_msb ^ c_out_msb.
  - Register Cout <= the final carry.
  - Go to DONE.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE unconditionally.
- Latency: start accepted at edge 0 → RUN edges 1..WIDTH → done high in the cycle after edge WIDTH. One operation takes WIDTH+2 cycles from start to IDLE.
- Result hold: S, Cout and ovf become final at edge WIDTH and hold until the next accepted start's first RUN edge. Intermediate S values during RUN are partial and not valid.
- busy=1 exactly in RUN; busy=0 in IDLE and DONE.
- start while in RUN or DONE is ignored; it is not queued. Operand changes after the accepting edge have no effect.
- start held high continuously: a new operation begins on the first edge in IDLE, i.e. back-to-back operations every WIDTH+2 cycles.
- Arithmetic: unsigned result {Cout,S} = A+B+Cin mod 2^(WIDTH+1). ovf is set when A and B have equal MSBs and S's MSB differs (with Cin included in the carry chain).
- rst_n asserted mid-RUN: the operation is aborted immediately, outputs go to reset values, and no done pulse occurs.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- With the macro defined:
  - sub=1 at the accepting edge loads b_sh<=~B and c<=1, ignoring Cin, so S=A-B mod 2^WIDTH.
  - Cout=1 means no borrow (A>=B unsigned).
  - ovf is signed subtraction overflow.
  - sub=0 behaves as plain addition.
- Without the macro: the sub port is present but unconnected internally; all operations are A+B+Cin.

Test Plan (WIDTH=8):
- Zero add: A=8'h00, B=8'h00, Cin=0, pulse start → done in cycle after edge 8; S=8'h00, Cout=0, ovf=0; busy high for exactly 8 cycles.
- Carry wrap: A=8'hFF, B=8'h01, Cin=0 → S=8'h00, Cout=1, ovf=0. Then A=8'h12, B=8'h34, Cin=1 → S=8'h47, Cout=0.
- Signed overflow: A=8'h7F, B=8'h01, Cin=0 → S=8'h80, Cout=0, ovf=1. Then A=8'h80, B=8'h80 → S=8'h00, Cout=1, ovf=1.
- Busy handling: start A=8'h0F, B=8'h01. Pulse start with A=8'hAA, B=8'h55 at RUN edge 3 and change A/B mid-RUN → result S=8'h10; only one done pulse. Result holds 8'h10 for 5 idle cycles after done.
- Reset mid-op: start A=8'hF0, B=8'h0F; drop rst_n between edges 4 and 5 → S=0, Cout=0, ovf=0, busy=0 immediately. No done pulse. After release, a fresh 8'h03+8'h04 gives S=8'h07.
- SERIAL_ADDER_SUB_EN defined: A=8'h05, B=8'h07, sub=1 → S=8'hFE, Cout=0, ovf=0. A=8'h80, B=8'h01, sub=1 → S=8'h7F, Cout=1, ovf=1.
